uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among NUM_REQ byte producers using round-robin arbitration.
- Accepts one byte per grant and launches it with a one-cycle data-valid pulse.
- Tracks the transmitter's active and done outputs until the line is free again.
- Sits between the client blocks (command/status/debug sources) and the single tx instance; it is that transmitter's only driver.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rr_arbiter_comb.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter and related blocks.
package uart_pkg;

  // Arbiter sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_ACT  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DRAIN     = 3'd4
  } arb_state_t;

  // One UART frame: start bit, 8 data bits, stop bit.
  localparam int unsigned FRAME_BITS = 10;

  // Smallest launch-to-done timeout that still covers one complete frame
  // plus the launch and done-recognition cycles.
  function automatic int unsigned min_timeout_cycles(input int unsigned clks_per_bit);
    return FRAME_BITS * clks_per_bit + 2;
  endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// Purely combinational round-robin picker: scans the request vector starting
// at i_ptr and wrapping, returning the first active requester.
module rr_arbiter_comb #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  // Rotating priority search; the first hit wins and later hits are ignored.
  always_comb begin
    int k;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(i_ptr) + i;
      if (k >= N) begin
        k = k - N;
      end
      if (!o_any && i_req[k]) begin
        o_any    = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of a single UART transmitter among NUM_REQ byte
// producers. One byte is accepted per grant, launched with a single-cycle
// data-valid pulse, and the line is then tracked until the transmitter is
// fully idle again (or a timeout abandons the byte).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_byte,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx_dv,
  output logic [7:0]           o_tx_byte,
  input  logic                 i_tx_act,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tx_dv_q, tx_dv_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic [7:0]         req_bytes [NUM_REQ];
  logic [7:0]         sel_byte;
  logic               timed_out;

  // Unpack the flat byte bus into one lane per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign req_bytes[gi] = i_req_byte[8*gi +: 8];
  end

  rr_arbiter_comb #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_rr (
    .i_req (i_req_valid),
    .i_ptr (rr_ptr_q),
    .o_gnt (arb_gnt),
    .o_idx (arb_idx),
    .o_any (arb_any)
  );

  // Select the granted requester's byte; the grant is one-hot so OR-ing is safe.
  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_gnt[k]) begin
        sel_byte = sel_byte | req_bytes[k];
      end
    end
  end

  assign timed_out = (tmo_cnt_q >= CNT_LAST);

  // Next-state logic, handshake outputs and timeout tracking.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    tx_byte_d   = tx_byte_q;
    grant_id_d  = grant_id_q;
    tmo_cnt_d   = tmo_cnt_q;
    o_req_ready = '0;
    o_err       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Ready is masked during reset so nothing can appear accepted.
        if (arb_any && i_rst_n) begin
          o_req_ready = arb_gnt;
          tx_byte_d   = sel_byte;
          grant_id_d  = arb_idx;
          rr_ptr_d    = (arb_idx == LAST_ID) ? '0 : arb_idx + 1'b1;
          state_d     = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT_ACT;
      end

      ST_WAIT_ACT: begin
        if (tmo_cnt_q != CNT_MAX) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        // A done seen before act means the frame already finished.
        if (i_tx_done) begin
          state_d = ST_DRAIN;
        end else if (i_tx_act) begin
          state_d = ST_WAIT_DONE;
        end else if (timed_out) begin
          o_err   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_DONE: begin
        if (tmo_cnt_q != CNT_MAX) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        if (i_tx_done) begin
          state_d = ST_DRAIN;
        end else if (timed_out) begin
          o_err   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        // Wait for a fully quiet transmitter so a long done is consumed once.
        if (!i_tx_done && !i_tx_act) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tx_dv_d = (state_d == ST_LAUNCH);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      tx_byte_q  <= '0;
      grant_id_q <= '0;
      tmo_cnt_q  <= '0;
      tx_dv_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_byte_q  <= tx_byte_d;
      grant_id_q <= grant_id_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tx_dv_q    <= tx_dv_d;
    end
  end

  assign o_tx_dv    = tx_dv_q;
  assign o_tx_byte  = tx_byte_q;
  assign o_grant_id = grant_id_q;
  assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ      = 4;
  localparam int TMO       = 16;
  localparam int CPB       = 1;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_byte;
  logic [NREQ-1:0]   ready;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_act;
  logic              tx_done;
  logic              busy;
  logic [1:0]        grant_id;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  // Transmitter model controls
  bit model_en  = 1'b1;
  int done_len  = 1;
  int mdl_cnt;
  int mdl_done_cnt;
  bit hold_valid = 1'b0;

  // Monitor records
  int       log_id[$];
  int       log_byte[$];
  int       viol_dv_act    = 0;
  int       viol_ready     = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_byte  (req_byte),
    .o_req_ready (ready),
    .o_tx_dv     (tx_dv),
    .o_tx_byte   (tx_byte),
    .i_tx_act    (tx_act),
    .i_tx_done   (tx_done),
    .o_busy      (busy),
    .o_grant_id  (grant_id),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: act for one frame after dv, then done for done_len cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_act       <= 1'b0;
      tx_done      <= 1'b0;
      mdl_cnt      <= 0;
      mdl_done_cnt <= 0;
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        tx_act       <= 1'b0;
        tx_done      <= 1'b1;
        mdl_done_cnt <= done_len;
      end
    end else if (mdl_done_cnt != 0) begin
      mdl_done_cnt <= mdl_done_cnt - 1;
      if (mdl_done_cnt == 1) tx_done <= 1'b0;
    end else if (model_en && tx_dv) begin
      tx_act  <= 1'b1;
      mdl_cnt <= FRAME_CYC;
    end
  end

  // Monitor: log every launch and count protocol violations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_dv) begin
        log_id.push_back(int'(grant_id));
        log_byte.push_back(int'(tx_byte));
        $display("[%0t] launch id=%0d byte=0x%02h", $time, grant_id, tx_byte);
      end
      if (tx_dv && tx_act) viol_dv_act++;
      if (ready != '0 && (busy || $countones(ready) != 1)) viol_ready++;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance from one negedge to the next, retiring any request accepted now.
  task automatic nstep();
    logic [NREQ-1:0] acc;
    acc = req_valid & ready;
    @(posedge clk);
    #1;
    if (!hold_valid) req_valid = req_valid & ~acc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      nstep();
      n++;
    end
  endtask

  function automatic int log_at(input int idx);
    if (idx < log_id.size()) return log_id[idx];
    return -1;
  endfunction

  function automatic int byte_at(input int idx);
    if (idx < log_byte.size()) return log_byte[idx];
    return -1;
  endfunction

  int n;
  int base;
  int exp_ids[5]   = '{0, 1, 2, 3, 0};
  int exp_bytes[5] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h10};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_byte  = '0;
    do_reset();

    // Reset state
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_dv", 32'(tx_dv), 32'd0);
    check_val("rst_ready", 32'(ready), 32'd0);
    check_val("rst_byte", 32'(tx_byte), 32'd0);
    check_val("rst_grant", 32'(grant_id), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);

    // Single request from requester 1
    base = log_id.size();
    req_byte[15:8] = 8'hA5;
    req_valid      = 4'b0010;
    #1;
    check_val("t1_ready", 32'(ready), 32'h2);
    nstep();
    check_val("t1_dv", 32'(tx_dv), 32'd1);
    check_val("t1_byte", 32'(tx_byte), 32'hA5);
    check_val("t1_grant", 32'(grant_id), 32'd1);
    check_val("t1_ready_after", 32'(ready), 32'd0);
    check_val("t1_busy", 32'(busy), 32'd1);
    nstep();
    check_val("t1_dv_single", 32'(tx_dv), 32'd0);
    wait_idle(n);
    check_val("t1_drain_cycles", 32'(n), 32'd12);
    check_val("t1_launches", 32'(log_id.size() - base), 32'd1);

    // All four valid continuously: round-robin order from pointer 0
    do_reset();
    base       = log_id.size();
    hold_valid = 1'b1;
    req_byte   = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid  = 4'b1111;
    n = 0;
    while ((log_id.size() - base) < 5 && n < 500) begin
      nstep();
      #1;
      n++;
    end
    req_valid  = '0;
    hold_valid = 1'b0;
    wait_idle(n);
    repeat (3) nstep();
    #1;
    check_val("t2_launches", 32'(log_id.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("t2_id%0d", i), 32'(log_at(base + i)), 32'(exp_ids[i]));
      check_val($sformatf("t2_byte%0d", i), 32'(byte_at(base + i)), 32'(exp_bytes[i]));
    end

    // Done held two cycles; requester 3 arrives while done is high
    do_reset();
    base     = log_id.size();
    done_len = 2;
    req_byte = {8'h77, 8'h00, 8'h00, 8'h3C};
    req_valid = 4'b0001;
    #1;
    check_val("t3_ready", 32'(ready), 32'h1);
    nstep();
    check_val("t3_dv_byte", 32'(tx_byte), 32'h3C);
    n = 0;
    while (!tx_done && n < 100) begin
      nstep();
      n++;
    end
    req_valid[3] = 1'b1;
    #1;
    check_val("t3_no_early_ready", 32'(ready), 32'd0);
    n = 0;
    while (ready == '0 && n < 50) begin
      nstep();
      n++;
    end
    check_val("t3_grant_delay", 32'(n), 32'd3);
    check_val("t3_ready3", 32'(ready), 32'h8);
    check_val("t3_idle_at_grant", 32'(busy), 32'd0);
    check_val("t3_one_transfer", 32'(log_id.size() - base), 32'd1);
    nstep();
    check_val("t3_dv3", 32'(tx_dv), 32'd1);
    check_val("t3_byte3", 32'(tx_byte), 32'h77);
    check_val("t3_grant3", 32'(grant_id), 32'd3);
    wait_idle(n);
    check_val("t3_drain_cycles", 32'(n), 32'd14);
    done_len = 1;

    // Silent transmitter: timeout after 16 cycles, then next requester
    do_reset();
    model_en = 1'b0;
    req_byte = {8'h00, 8'h66, 8'h55, 8'h00};
    req_valid = 4'b0110;
    #1;
    check_val("t4_ready", 32'(ready), 32'h2);
    nstep();
    check_val("t4_dv", 32'(tx_dv), 32'd1);
    n = 0;
    while (!err && n < 40) begin
      nstep();
      n++;
    end
    check_val("t4_err_cycle", 32'(n), 32'd16);
    check_val("t4_busy_at_err", 32'(busy), 32'd1);
    nstep();
    check_val("t4_err_pulse", 32'(err), 32'd0);
    check_val("t4_idle", 32'(busy), 32'd0);
    check_val("t4_next_ready", 32'(ready), 32'h4);
    nstep();
    check_val("t4_next_grant", 32'(grant_id), 32'd2);
    check_val("t4_next_byte", 32'(tx_byte), 32'h66);
    do_reset();
    model_en = 1'b1;

    // Asynchronous reset in the middle of a frame
    req_byte = {8'h00, 8'h00, 8'hC3, 8'h00};
    req_valid = 4'b0010;
    #1;
    nstep();
    repeat (6) nstep();
    check_val("t5_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    req_byte[23:16] = 8'h5A;
    req_valid = 4'b0100;
    #1;
    check_val("t5_rst_dv", 32'(tx_dv), 32'd0);
    check_val("t5_rst_byte", 32'(tx_byte), 32'd0);
    check_val("t5_rst_ready", 32'(ready), 32'd0);
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_grant", 32'(grant_id), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("t5_ready2", 32'(ready), 32'h4);
    nstep();
    check_val("t5_dv", 32'(tx_dv), 32'd1);
    check_val("t5_grant", 32'(grant_id), 32'd2);
    check_val("t5_byte", 32'(tx_byte), 32'h5A);
    wait_idle(n);
    check_val("t5_grant_hold", 32'(grant_id), 32'd2);

    // Protocol invariants over the whole run
    check_val("no_dv_while_act", 32'(viol_dv_act), 32'd0);
    check_val("ready_only_idle_onehot", 32'(viol_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
